// File: rtl/midi_learn_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// midi_pkg : shared MIDI message type, byte-class constants and length rule
// Rev 1.0
// ----------------------------------------------------------------------------
package midi_pkg;

    localparam logic [7:0] MIDI_RT_MIN  = 8'hF8;
    localparam logic [7:0] MIDI_SYS_MIN = 8'hF0;
    localparam logic [3:0] CC_STATUS    = 4'hB;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] len;
    } msg_t;

    // Program change and channel pressure carry one data byte, the rest two.
    function automatic logic [1:0] msg_len(input logic [7:0] status);
        if (status[7:4] == 4'hC || status[7:4] == 4'hD) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_learn_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// midi_learn_ctrl_if : button pulses, MIDI serial lines and status indicators
// Rev 1.0
// ----------------------------------------------------------------------------
interface midi_learn_ctrl_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_rise;
    logic               midi_rx;
    logic               midi_tx;
    logic               led_learn;
    logic               led_busy;
    logic               rx_frame_err;

    modport master (
        output btn_rise, midi_rx,
        input  midi_tx, led_learn, led_busy, rx_frame_err
    );

    modport slave (
        input  btn_rise, midi_rx,
        output midi_tx, led_learn, led_busy, rx_frame_err
    );
endinterface
`default_nettype wire

// File: rtl/midi_learn_ctrl_uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// midi_uart_rx : synchronised 8N1 receiver with mid-bit sampling and frame check
// Rev 1.0
// ----------------------------------------------------------------------------
module midi_uart_rx #(
    parameter int CLKS_PER_BIT = 3200
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       rx,
    output logic            byte_valid,
    output logic [7:0]      rx_byte,
    output logic            frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state, state_next;
    logic [2:0]    sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shifter;
    logic          rx_s, fall, bit_tick, half_tick;

    // sync[1:0] is the metastability chain, sync[2] the previous sample for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], rx};
        end
    end

    assign rx_s      = sync[1];
    assign fall      = sync[2] & ~sync[1];
    assign bit_tick  = (cnt == BIT_LAST);
    assign half_tick = (cnt == HALF_LAST);
    assign rx_byte   = shifter;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (fall) state_next = S_START;
            S_START: if (half_tick) state_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (bit_tick && bit_cnt == 3'd7) state_next = S_STOP;
            S_STOP:  if (bit_tick) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shifter <= '0;
        end else begin
            if (state == S_IDLE || bit_tick || (state == S_START && half_tick)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state == S_START) begin
                bit_cnt <= '0;
            end else if (state == S_DATA && bit_tick) begin
                bit_cnt <= bit_cnt + 3'd1;
                shifter <= {rx_s, shifter[7:1]};
            end
        end
    end

    always_comb begin
        byte_valid = (state == S_STOP) && bit_tick && rx_s;
        frame_err  = ((state == S_START) && half_tick && rx_s) ||
                     ((state == S_STOP) && bit_tick && !rx_s);
    end

endmodule
`default_nettype wire

// File: rtl/midi_learn_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// midi_learn_ctrl : footswitch-to-MIDI sender with slot learning from MIDI IN
// Rev 1.0
// ----------------------------------------------------------------------------
module midi_learn_ctrl
    import midi_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int CLKS_PER_BIT = 3200,
    parameter int DEF_CHANNEL  = 0,
    parameter int FIRST_CC     = 46,
    parameter int DEF_VALUE    = 127
) (
    input  wire logic        clk,
    input  wire logic        rst,
    midi_learn_ctrl_if.slave bus
);
    localparam int IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_START = 3'd1;
    localparam logic [2:0] TX_DATA  = 3'd2;
    localparam logic [2:0] TX_STOP  = 3'd3;
    localparam logic [2:0] TX_NEXT  = 3'd4;

    function automatic logic [IW-1:0] lowest_set(input logic [NUM_BTN-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] msg_byte(input msg_t m, input logic [1:0] idx);
        case (idx)
            2'd0:    return m.status;
            2'd1:    return m.d1;
            default: return m.d2;
        endcase
    endfunction

    logic                rx_valid, rx_err;
    logic [7:0]          rx_byte;
    logic [7:0]          run_status, data_d1;
    logic                run_valid, data_idx, msg_done;
    logic [1:0]          run_len;
    msg_t                msg_new, learn_buf, cur;
    msg_t                slot [NUM_BTN];
    logic                armed, assign_req, load;
    logic [IW-1:0]       assign_idx, take_idx;
    logic [NUM_BTN-1:0]  pending, take_mask;
    logic [2:0]          tx_state, tx_next, bit_idx;
    logic [CW-1:0]       tx_cnt;
    logic [1:0]          byte_idx;
    logic [7:0]          shreg;
    logic                tx_tick, stop_end, more_bytes;

    midi_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (bus.midi_rx),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .frame_err  (rx_err)
    );

    // A data byte completes a message on the second data byte, or the first for 2-byte types
    always_comb begin
        run_len        = msg_len(run_status);
        msg_done       = rx_valid && !rx_byte[7] && run_valid && (data_idx || run_len == 2'd2);
        msg_new.status = run_status;
        msg_new.d1     = data_idx ? data_d1 : rx_byte;
        msg_new.d2     = data_idx ? rx_byte : 8'h00;
        msg_new.len    = run_len;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_status <= '0;
            run_valid  <= 1'b0;
            data_idx   <= 1'b0;
            data_d1    <= '0;
        end else if (rx_valid) begin
            if (rx_byte[7] && rx_byte < MIDI_SYS_MIN) begin
                run_status <= rx_byte;
                run_valid  <= 1'b1;
                data_idx   <= 1'b0;
            end else if (rx_byte >= MIDI_SYS_MIN && rx_byte < MIDI_RT_MIN) begin
                run_valid <= 1'b0;
                data_idx  <= 1'b0;
            end else if (!rx_byte[7] && run_valid) begin
                data_d1  <= rx_byte;
                data_idx <= !msg_done;
            end
        end
    end

    assign assign_req = armed && (|bus.btn_rise);
    assign assign_idx = lowest_set(bus.btn_rise);

    // A completion in the same clk as an assignment wins: armed stays set with the new buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed     <= 1'b0;
            learn_buf <= '0;
        end else begin
            if (msg_done) begin
                armed     <= 1'b1;
                learn_buf <= msg_new;
            end else if (assign_req) begin
                armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                slot[i] <= '{status: {CC_STATUS, 4'(DEF_CHANNEL)},
                             d1:     8'(FIRST_CC + i),
                             d2:     8'(DEF_VALUE),
                             len:    2'd3};
            end
        end else if (assign_req) begin
            slot[assign_idx] <= learn_buf;
        end
    end

    assign take_idx = lowest_set(pending);

    always_comb begin
        take_mask = '0;
        if (load) take_mask[take_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~take_mask) | (armed ? '0 : bus.btn_rise);
        end
    end

    assign tx_tick    = (tx_cnt == BIT_LAST);
    assign stop_end   = (tx_cnt == STOP_LAST);
    assign more_bytes = ({1'b0, byte_idx} + 3'd1) < {1'b0, cur.len};
    assign load       = (|pending) && (tx_state == TX_IDLE || (tx_state == TX_NEXT && !more_bytes));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // NEXT is the last clk of the stop bit, so chained bytes and messages stay gapless
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (|pending) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && bit_idx == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (stop_end) tx_next = TX_NEXT;
            TX_NEXT:  tx_next = (more_bytes || (|pending)) ? TX_START : TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt   <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            cur      <= '0;
        end else begin
            if (((tx_state == TX_START || tx_state == TX_DATA) && !tx_tick) ||
                (tx_state == TX_STOP && !stop_end)) begin
                tx_cnt <= tx_cnt + CW'(1);
            end else begin
                tx_cnt <= '0;
            end
            if (load) begin
                cur      <= slot[take_idx];
                shreg    <= slot[take_idx].status;
                byte_idx <= '0;
                bit_idx  <= '0;
            end else if (tx_state == TX_DATA && tx_tick) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end else if (tx_state == TX_NEXT && more_bytes) begin
                byte_idx <= byte_idx + 2'd1;
                shreg    <= msg_byte(cur, byte_idx + 2'd1);
            end
        end
    end

    always_comb begin
        bus.midi_tx = 1'b1;
        case (tx_state)
            TX_START: bus.midi_tx = 1'b0;
            TX_DATA:  bus.midi_tx = shreg[0];
            default:  bus.midi_tx = 1'b1;
        endcase
        bus.led_busy     = (tx_state != TX_IDLE) || (|pending);
        bus.led_learn    = armed;
        bus.rx_frame_err = rx_err;
    end

endmodule
`default_nettype wire
